// File: rtl/data_mem_arbiter.sv
// Two-requester (core / debug loader) arbiter for a single-port data memory.
// One access per cycle, round-robin on ties, registered memory-side and
// grant outputs, per-port read-data registers with a one-cycle rvalid pulse.
module data_mem_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    // core-side requester
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    // debug / loader requester
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,
    // shared memory
    output logic              mem_enable,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CPU_ACC = 2'd1,
        DBG_ACC = 2'd2
    } state_t;

    state_t state;
    // set when the debug port won the most recent grant; reset value makes
    // the core win the first tie
    logic   last_dbg;

    logic cpu_elig;
    logic dbg_elig;
    logic pick_cpu;
    logic pick_dbg;

    // A port whose access is being performed this cycle has its request
    // consumed at the closing edge, so it cannot win that same edge.
    always_comb begin
        cpu_elig = cpu_req && (state != CPU_ACC);
        dbg_elig = dbg_req && (state != DBG_ACC);
        pick_cpu = cpu_elig && (!dbg_elig || last_dbg);
        pick_dbg = dbg_elig && !pick_cpu;
    end

    assign busy = (state != IDLE);

    // Arbitration FSM: latch the winner's access, drive memory and grants,
    // and complete the previous cycle's read into the owning port.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            last_dbg   <= 1'b1;
            cpu_gnt    <= 1'b0;
            dbg_gnt    <= 1'b0;
            cpu_rvalid <= 1'b0;
            dbg_rvalid <= 1'b0;
            cpu_rdata  <= '0;
            dbg_rdata  <= '0;
            mem_enable <= 1'b0;
            mem_write  <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            // read completion: mem_write still holds the latched we here
            cpu_rvalid <= (state == CPU_ACC) && !mem_write;
            dbg_rvalid <= (state == DBG_ACC) && !mem_write;
            if ((state == CPU_ACC) && !mem_write)
                cpu_rdata <= mem_rdata;
            if ((state == DBG_ACC) && !mem_write)
                dbg_rdata <= mem_rdata;

            if (pick_cpu) begin
                state      <= CPU_ACC;
                last_dbg   <= 1'b0;
                cpu_gnt    <= 1'b1;
                dbg_gnt    <= 1'b0;
                mem_enable <= 1'b1;
                mem_write  <= cpu_we;
                mem_addr   <= cpu_addr;
                mem_wdata  <= cpu_wdata;
            end else if (pick_dbg) begin
                state      <= DBG_ACC;
                last_dbg   <= 1'b1;
                cpu_gnt    <= 1'b0;
                dbg_gnt    <= 1'b1;
                mem_enable <= 1'b1;
                mem_write  <= dbg_we;
                mem_addr   <= dbg_addr;
                mem_wdata  <= dbg_wdata;
            end else begin
                // address/data hold their last values while idle
                state      <= IDLE;
                cpu_gnt    <= 1'b0;
                dbg_gnt    <= 1'b0;
                mem_enable <= 1'b0;
                mem_write  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Self-checking bench for data_mem_arbiter: directed scenarios plus a random
// two-requester run, all scored against a transaction-level model.
module tb_data_mem_arbiter;

    localparam int AW = 8;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          cpu_req = 1'b0, cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic          cpu_gnt, cpu_rvalid;
    logic [DW-1:0] cpu_rdata;
    logic          dbg_req = 1'b0, dbg_we = 1'b0;
    logic [AW-1:0] dbg_addr = '0;
    logic [DW-1:0] dbg_wdata = '0;
    logic          dbg_gnt, dbg_rvalid;
    logic [DW-1:0] dbg_rdata;
    logic          mem_enable, mem_write, busy;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    data_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
        .mem_enable(mem_enable), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    // the physical memory the DUT drives
    logic [DW-1:0] mem [256];
    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) if (mem_enable && mem_write) mem[mem_addr] <= mem_wdata;

    // ---------------- reference model (one access record per cycle) -------
    logic [DW-1:0] mmem [256];
    int            m_gnt;      // 0 none, 1 cpu, 2 dbg: who owns this cycle
    int            m_last;     // who won the most recent grant
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_crdata, m_drdata;
    logic          m_crv, m_drv;

    task automatic model_reset();
        m_gnt = 0; m_last = 2; m_we = 0; m_addr = '0; m_wdata = '0;
        m_crdata = '0; m_drdata = '0; m_crv = 0; m_drv = 0;
    endtask

    // retire the current access, choose the next owner, then clock once
    task automatic tick();
        logic c_ok, d_ok;
        int   w;
        m_crv = 0; m_drv = 0;
        if (m_gnt == 1 && !m_we) begin m_crv = 1; m_crdata = mmem[m_addr]; end
        if (m_gnt == 2 && !m_we) begin m_drv = 1; m_drdata = mmem[m_addr]; end
        if (m_gnt != 0 && m_we) mmem[m_addr] = m_wdata;
        c_ok = cpu_req && (m_gnt != 1);
        d_ok = dbg_req && (m_gnt != 2);
        if (c_ok && d_ok) w = (m_last == 1) ? 2 : 1;
        else if (c_ok)    w = 1;
        else if (d_ok)    w = 2;
        else              w = 0;
        if (w == 1) begin m_we = cpu_we; m_addr = cpu_addr; m_wdata = cpu_wdata; end
        if (w == 2) begin m_we = dbg_we; m_addr = dbg_addr; m_wdata = dbg_wdata; end
        if (w != 0) m_last = w;
        m_gnt = w;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [38:0] obs();
        return {cpu_gnt, cpu_rvalid, cpu_rdata, dbg_gnt, dbg_rvalid, dbg_rdata,
                mem_enable, mem_write, mem_addr, mem_wdata, busy};
    endfunction

    function automatic logic [38:0] expv();
        return {m_gnt == 1, m_crv, m_crdata, m_gnt == 2, m_drv, m_drdata,
                m_gnt != 0, (m_gnt != 0) && m_we, m_addr, m_wdata, m_gnt != 0};
    endfunction

    task automatic idle_inputs();
        cpu_req = 0; cpu_we = 0; dbg_req = 0; dbg_we = 0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        idle_inputs();
        model_reset();
        #3;
        n_checks++;
        if (obs() !== 39'd0) begin
            n_fail++; $display("FAIL reset_initial: got %h want 0", obs());
        end
        rst = 1;
        // some traffic, then pull reset mid-cycle with no clock edge
        cpu_req = 1; cpu_we = 1; cpu_addr = 8'h33; cpu_wdata = 8'h99;
        tick();
        n_checks++;
        if (obs() !== expv()) begin
            n_fail++; $display("FAIL reset_pre_traffic: got %h want %h", obs(), expv());
        end
        #2 rst = 0;
        #1;
        model_reset();
        n_checks++;
        if (obs() !== 39'd0) begin
            n_fail++; $display("FAIL reset_async: got %h want 0", obs());
        end
        idle_inputs();
        @(posedge clk);
        #2 rst = 1;
    endtask

    task automatic test_cpu_write();
        logic [DW-1:0] d_before;
        d_before = dbg_rdata;
        cpu_req = 1; cpu_we = 1; cpu_addr = 8'h10; cpu_wdata = 8'hA5;
        tick();
        n_checks++;
        if ({mem_enable, mem_write, mem_addr, mem_wdata, cpu_gnt, dbg_gnt} !== {1'b1, 1'b1, 8'h10, 8'hA5, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL cpu_write_access: en=%b wr=%b a=%h d=%h cg=%b dg=%b want 1 1 10 a5 1 0",
                     mem_enable, mem_write, mem_addr, mem_wdata, cpu_gnt, dbg_gnt);
        end
        cpu_req = 0; cpu_addr = 8'hFF; cpu_wdata = 8'h00;
        tick();
        n_checks++;
        if ({busy, cpu_rvalid, dbg_rvalid, mem_enable, mem_addr} !== {4'b0000, 8'h10}) begin
            n_fail++;
            $display("FAIL cpu_write_after: busy=%b crv=%b drv=%b en=%b a=%h want 0 0 0 0 10",
                     busy, cpu_rvalid, dbg_rvalid, mem_enable, mem_addr);
        end
        n_checks++;
        if (d_before !== dbg_rdata) begin
            n_fail++; $display("FAIL cpu_write_dbg_rdata: got %h want %h", dbg_rdata, d_before);
        end
    endtask

    task automatic test_cpu_read();
        logic [DW-1:0] d_before;
        d_before = dbg_rdata;
        cpu_req = 1; cpu_we = 0; cpu_addr = 8'h10;
        tick();
        n_checks++;
        if ({cpu_gnt, dbg_gnt, mem_enable, mem_write} !== 4'b1010) begin
            n_fail++; $display("FAIL cpu_read_gnt: cg=%b dg=%b en=%b wr=%b want 1 0 1 0",
                               cpu_gnt, dbg_gnt, mem_enable, mem_write);
        end
        cpu_req = 0;
        tick();
        n_checks++;
        if ({cpu_rvalid, cpu_rdata, dbg_rdata} !== {1'b1, 8'hA5, d_before}) begin
            n_fail++; $display("FAIL cpu_read_data: rv=%b rd=%h dbg_rd=%h want 1 a5 %h",
                               cpu_rvalid, cpu_rdata, dbg_rdata, d_before);
        end
        tick();
        n_checks++;
        if ({cpu_rvalid, cpu_rdata} !== {1'b0, 8'hA5}) begin
            n_fail++; $display("FAIL cpu_read_hold: rv=%b rd=%h want 0 a5", cpu_rvalid, cpu_rdata);
        end
    endtask

    task automatic test_contention();
        logic [1:0] want;
        // reset so the round-robin pointer is known, both requests held high
        #2 rst = 0;
        model_reset();
        cpu_req = 1; cpu_we = 1; cpu_addr = 8'h40; cpu_wdata = 8'h11;
        dbg_req = 1; dbg_we = 1; dbg_addr = 8'h41; dbg_wdata = 8'h22;
        @(posedge clk);
        #2 rst = 1;
        for (int i = 0; i < 6; i++) begin
            tick();
            want = (i % 2 == 0) ? 2'b10 : 2'b01;
            n_checks++;
            if ({cpu_gnt, dbg_gnt, busy} !== {want, 1'b1}) begin
                n_fail++; $display("FAIL contention_cyc%0d: cg/dg/busy=%b want %b1",
                                   i, {cpu_gnt, dbg_gnt, busy}, want);
            end
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_abort();
        dbg_req = 1; dbg_we = 0; dbg_addr = 8'h20;
        tick();
        n_checks++;
        if ({dbg_gnt, mem_addr} !== {1'b1, 8'h20}) begin
            n_fail++; $display("FAIL abort_gnt: dg=%b a=%h want 1 20", dbg_gnt, mem_addr);
        end
        #2 rst = 0;
        #1;
        model_reset();
        n_checks++;
        if (obs() !== 39'd0) begin
            n_fail++; $display("FAIL abort_reset: got %h want 0", obs());
        end
        cpu_req = 1; cpu_we = 0; cpu_addr = 8'h21;
        @(posedge clk);
        #2 rst = 1;
        tick();
        n_checks++;
        if ({cpu_gnt, dbg_gnt, dbg_rvalid} !== 3'b100) begin
            n_fail++; $display("FAIL abort_first_gnt: cg=%b dg=%b drv=%b want 1 0 0",
                               cpu_gnt, dbg_gnt, dbg_rvalid);
        end
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (obs() !== expv()) begin
                n_fail++; $display("FAIL abort_after_cyc%0d: got %h want %h", i, obs(), expv());
            end
        end
    endtask

    task automatic test_interleave();
        mem[8'h05] = 8'h3C; mmem[8'h05] = 8'h3C;
        mem[8'h06] = 8'h7E; mmem[8'h06] = 8'h7E;
        dbg_req = 1; dbg_we = 0; dbg_addr = 8'h05;
        tick();
        dbg_req = 0; dbg_addr = 8'hEE;
        cpu_req = 1; cpu_we = 0; cpu_addr = 8'h06;
        tick();
        n_checks++;
        if ({cpu_gnt, dbg_rvalid, dbg_rdata, cpu_rvalid} !== {1'b1, 1'b1, 8'h3C, 1'b0}) begin
            n_fail++; $display("FAIL interleave_dbg: cg=%b drv=%b drd=%h crv=%b want 1 1 3c 0",
                               cpu_gnt, dbg_rvalid, dbg_rdata, cpu_rvalid);
        end
        cpu_req = 0;
        tick();
        n_checks++;
        if ({cpu_rvalid, cpu_rdata, dbg_rvalid, dbg_rdata} !== {1'b1, 8'h7E, 1'b0, 8'h3C}) begin
            n_fail++; $display("FAIL interleave_cpu: crv=%b crd=%h drv=%b drd=%h want 1 7e 0 3c",
                               cpu_rvalid, cpu_rdata, dbg_rvalid, dbg_rdata);
        end
        tick();
        n_checks++;
        if ({cpu_rvalid, dbg_rvalid, busy} !== 3'b000) begin
            n_fail++; $display("FAIL interleave_tail: crv=%b drv=%b busy=%b want 0 0 0",
                               cpu_rvalid, dbg_rvalid, busy);
        end
    endtask

    task automatic test_random();
        logic c_pend, d_pend;
        int   errs;
        c_pend = 0; d_pend = 0; errs = 0;
        for (int i = 0; i < 16; i++) begin
            mem[i] = 8'($urandom); mmem[i] = mem[i];
        end
        for (int cyc = 0; cyc < 400; cyc++) begin
            // a requester drops or re-issues only once it has been granted
            if (m_gnt == 1) c_pend = 0;
            if (m_gnt == 2) d_pend = 0;
            if (!c_pend) begin
                c_pend = ($urandom_range(0, 99) < 55);
                cpu_we = 1'($urandom); cpu_addr = 8'($urandom_range(0, 15)); cpu_wdata = 8'($urandom);
            end
            if (!d_pend) begin
                d_pend = ($urandom_range(0, 99) < 55);
                dbg_we = 1'($urandom); dbg_addr = 8'($urandom_range(0, 15)); dbg_wdata = 8'($urandom);
            end
            cpu_req = c_pend; dbg_req = d_pend;
            tick();
            n_checks++;
            if (obs() !== expv()) begin
                n_fail++;
                if (errs < 10) $display("FAIL random_cyc%0d: got %h want %h", cyc, obs(), expv());
                errs++;
            end
            n_checks++;
            if (cpu_gnt && dbg_gnt) begin
                n_fail++; $display("FAIL random_dual_gnt_cyc%0d: cg=%b dg=%b want not both", cyc, cpu_gnt, dbg_gnt);
            end
        end
        idle_inputs();
        tick();
        tick();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin mem[i] = '0; mmem[i] = '0; end
        test_reset();
        test_cpu_write();
        test_cpu_read();
        test_contention();
        test_abort();
        test_interleave();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/data_mem_arbiter.md
DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, data memory address width.
REQ-002 The block SHALL have parameter DATA_W, default 8, data memory word width.
REQ-003 The block SHALL have port clk  in  1  single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port rst  in  1  asynchronous, active-low reset.
REQ-005 The block SHALL have ports cpu_req  in  1, cpu_we  in  1, cpu_addr  in  ADDR_W, cpu_wdata  in  DATA_W; these are the core-side access request, write flag, address and write data.
REQ-006 The block SHALL have ports cpu_gnt  out  1, cpu_rvalid  out  1, cpu_rdata  out  DATA_W; these are the core-side grant, read-data-valid and read data.
REQ-007 The block SHALL have ports dbg_req, dbg_we, dbg_addr, dbg_wdata (inputs) and dbg_gnt, dbg_rvalid, dbg_rdata (outputs), with widths and meanings identical to the cpu_* ports, for the debug/loader requester.
REQ-008 The block SHALL have ports mem_enable  out  1, mem_write  out  1, mem_addr  out  ADDR_W, mem_wdata  out  DATA_W; these drive the shared data memory.
REQ-009 The block SHALL have port mem_rdata  in  DATA_W, the combinational read data from the memory for the current mem_addr.
REQ-010 The block SHALL have port busy  out  1, high whenever the state is not IDLE.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, CPU_ACC and DBG_ACC.
REQ-012 A requester SHALL hold req, we, addr and wdata stable from the cycle it asserts req until the cycle in which its gnt is high.
REQ-013 At each rising edge, the FSM SHALL arbitrate among eligible requests and latch the winner's we/addr/wdata.
  - Winner is CPU → next state CPU_ACC.
  - Winner is DBG → next state DBG_ACC.
  - No eligible request → next state IDLE.
REQ-014 In the edge that ends an X_ACC cycle, the block SHALL treat requester X's req as consumed and make it ineligible; X can win again no earlier than the following edge.
REQ-015 When both requests are eligible, the block SHALL grant the requester that did not win the most recent grant (round-robin); after reset, CPU wins the first tie.
REQ-016 In CPU_ACC (resp. DBG_ACC), the block SHALL drive:
  - mem_enable=1;
  - mem_write = latched we;
  - mem_addr and mem_wdata = latched values;
  - cpu_gnt=1 (resp. dbg_gnt=1) for exactly that cycle.
  The other gnt SHALL be 0.
REQ-017 In IDLE, mem_enable and mem_write SHALL be 0, and mem_addr/mem_wdata SHALL hold their last values.
REQ-018 Access latency SHALL be 1 cycle: a req sampled at edge N into a free arbiter yields gnt and the memory access in cycle N+1.
REQ-019 Back-to-back accesses by alternating requesters SHALL proceed at one access per cycle with no IDLE gap.
REQ-020 For a read access (latched we=0), the block SHALL capture mem_rdata into the granted port's rdata register at the edge ending the ACC cycle.
REQ-021 For that read, the block SHALL pulse the granted port's rvalid high for exactly the following cycle.
REQ-022 For writes, the block SHALL NOT pulse rvalid.
REQ-023 cpu_rdata and dbg_rdata SHALL be independent registers; each SHALL hold its value until that port's next read completes.
REQ-024 The block SHALL ignore we/addr/wdata of a non-requesting port.
REQ-025 The block SHALL NOT assert both gnt signals in the same cycle.
REQ-026 The block SHALL NOT assert a gnt without the matching req having been sampled high at the previous edge.

Reset
REQ-027 While rst=0, the block SHALL hold the following immediately, independent of clk:
  - state=IDLE;
  - cpu_gnt=dbg_gnt=0, cpu_rvalid=dbg_rvalid=0;
  - mem_enable=mem_write=0, busy=0;
  - mem_addr=0, mem_wdata=0;
  - cpu_rdata=dbg_rdata=0;
  - round-robin pointer set so CPU wins the next tie.
REQ-028 Reset asserted during an ACC cycle SHALL abort that access immediately; no rvalid SHALL follow it.
REQ-029 The first edge after rst returns high SHALL arbitrate normally per REQ-013 to REQ-015.

Verification
REQ-030 Reset: drive rst=0 mid-operation → all outputs go to the REQ-027 values without a clock edge.
REQ-031 CPU write: cpu_req=1, cpu_we=1, addr 0x10, wdata 0xA5 at edge 0 → cycle 1 shows mem_enable=1, mem_write=1, mem_addr=0x10, mem_wdata=0xA5, cpu_gnt=1; cycle 2 shows busy=0 and no rvalid.
REQ-032 CPU read: addr 0x10, memory returns 0xA5 → cpu_gnt=1 in cycle 1; cpu_rvalid=1 and cpu_rdata=0xA5 in cycle 2; dbg_rdata unchanged.
REQ-033 Contention: both req held high continuously from reset release → grants alternate CPU, DBG, CPU, DBG on consecutive cycles with no IDLE cycle.
REQ-034 Abort: rst=0 during a DBG_ACC read of addr 0x20 → dbg_rvalid never pulses; after release with both req high, CPU is granted first.
REQ-035 Interleave: DBG read addr 0x05 (data 0x3C) then CPU read addr 0x06 (data 0x7E) back-to-back → dbg_rdata=0x3C, cpu_rdata=0x7E, each rvalid a single-cycle pulse one cycle apart.
